// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU: magnitudes in, one bit per cycle through a
// shared adder/subtractor, sign fix-up at the end, result held in hi/lo.
module muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(ITER);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div;
    logic              r_neg_lo;
    logic              r_neg_hi;
    logic              r_dz;
    logic [XLEN-1:0]   r_acc_hi;
    logic [XLEN-1:0]   r_acc_lo;
    logic [XLEN-1:0]   r_b;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    op_t               w_op;
    logic              w_signed;
    logic              w_div;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic [XLEN+1:0]   w_sum;
    logic [XLEN-1:0]   w_nxt_hi;
    logic [XLEN-1:0]   w_nxt_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    assign w_op     = op_t'(op);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_div    = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_sa     = w_signed & a[XLEN-1];
    assign w_sb     = w_signed & b[XLEN-1];
    assign w_abs_a  = w_sa ? (~a + 1'b1) : a;
    assign w_abs_b  = w_sb ? (~b + 1'b1) : b;

    // Divide subtracts via a + ~b + 1; bit XLEN+1 is then "no borrow".
    assign w_add_a = r_is_div ? {r_acc_hi, r_acc_lo[XLEN-1]} : {1'b0, r_acc_hi};
    assign w_add_b = r_is_div ? ~{1'b0, r_b} : {1'b0, r_b};
    assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, r_is_div};

    always_comb begin
        w_nxt_hi = r_acc_hi;
        w_nxt_lo = r_acc_lo;
        if (r_is_div) begin
            if (w_sum[XLEN+1]) begin
                w_nxt_hi = w_sum[XLEN-1:0];
                w_nxt_lo = {r_acc_lo[XLEN-2:0], 1'b1};
            end else begin
                w_nxt_hi = w_add_a[XLEN-1:0];
                w_nxt_lo = {r_acc_lo[XLEN-2:0], 1'b0};
            end
        end else if (r_acc_lo[0]) begin
            w_nxt_hi = w_sum[XLEN:1];
            w_nxt_lo = {w_sum[0], r_acc_lo[XLEN-1:1]};
        end else begin
            w_nxt_hi = {1'b0, r_acc_hi[XLEN-1:1]};
            w_nxt_lo = {r_acc_hi[0], r_acc_lo[XLEN-1:1]};
        end
    end

    // Divide by zero leaves remainder = |a|, which the sign fix turns back into a.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_lo ? (~w_prod + 1'b1) : w_prod;
    assign w_q_fix    = r_dz ? {XLEN{1'b1}} : (r_neg_lo ? (~r_acc_lo + 1'b1) : r_acc_lo);
    assign w_r_fix    = r_neg_hi ? (~r_acc_hi + 1'b1) : r_acc_hi;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_is_div <= w_div;
                        r_neg_lo <= w_sa ^ w_sb;
                        r_neg_hi <= w_sa;
                        r_dz     <= w_div && (b == '0);
                        r_acc_hi <= '0;
                        r_acc_lo <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc_hi <= w_nxt_hi;
                        r_acc_lo <= w_nxt_lo;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CW'(ITER-1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_r_fix;
                            r_lo <= w_q_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                            r_lo <= w_prod_fix[XLEN-1:0];
                        end
                        r_done <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: results, latency, busy-start, flush and async reset.
module tb_muldiv;
    import muldiv_pkg::*;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int nd;

    muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input op_t o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int n);
        n = from;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input string tag, input op_t o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int n;
        start_op(o, x, y);
        wait_done(0, n);
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_busy", {31'd0, busy}, 32'd1);
        wait_done(0, cyc);
        chk("multu_lat", cyc, 33);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        chk("multu_busy_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);

        run("mult_neg",   OP_MULT, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run("div_neg",    OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_negb",   OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run("divu_zero",  OP_DIVU, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
        run("div_zero",   OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
        run("div_wrap",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run("mult_min",   OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        // start while busy is ignored
        start_op(OP_MULTU, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, cyc);
        chk("ign_lat", cyc, 33);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd42);

        // back-to-back start in the done cycle
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, cyc);
        chk("b2b_lat", cyc, 33);
        chk("b2b_hi", hi, 32'd1);
        chk("b2b_lo", lo, 32'd33);

        // flush mid-operation
        start_op(OP_MULT, 32'd5, 32'd5);
        repeat (13) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("flush_nodone", nd, 0);
        chk("flush_hi", hi, 32'd1);
        chk("flush_lo", lo, 32'd33);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("fs_busy", {31'd0, busy}, 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("fs_nodone", nd, 0);
        chk("fs_lo", lo, 32'd33);

        // asynchronous reset mid-divide
        start_op(OP_DIV, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run("post_rst", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
